// File: rtl/aes128_dec_key_store.sv
// AES-128 decryption round-key store.
// Expands a cipher key one round key per clock into an 11-entry register
// file and serves the keys in decryption order over a registered read port.
//
// state  | meaning
// IDLE   | no key loaded, waiting for a key handshake
// EXPAND | computing rk[cnt] from the previous round key each cycle
// READY  | all round keys present; a new handshake restarts expansion
module aes128_dec_key_store #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [127:0] key_in,
    output logic         key_ready,
    output logic         keys_valid,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    localparam logic [3:0] NR_L = 4'(NR);

    // Forward S-box, byte 0x00 at the most significant end.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t         state, state_nxt;
    logic [3:0]     cnt;
    logic [127:0]   rk [0:NR];
    logic [127:0]   work;
    logic [127:0]   next_rk;
    logic           handshake;

    assign handshake = key_valid && key_ready;

    // One key-schedule step from the previous round key held in work.
    always_comb begin
        logic [31:0] rot;
        logic [31:0] temp;
        logic [31:0] n0, n1, n2, n3;
        rot  = {work[23:0], work[31:24]};
        temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon(cnt), 24'h0};
        n0 = work[127:96] ^ temp;
        n1 = work[95:64]  ^ n0;
        n2 = work[63:32]  ^ n1;
        n3 = work[31:0]   ^ n2;
        next_rk = {n0, n1, n2, n3};
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt  = state;
        key_ready  = 1'b0;
        keys_valid = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) state_nxt = EXPAND;
            end
            EXPAND: begin
                if (cnt == NR_L) state_nxt = READY;
            end
            READY: begin
                key_ready  = 1'b1;
                keys_valid = 1'b1;
                if (key_valid) state_nxt = EXPAND;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and round counter; the counter holds at NR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (handshake)
                cnt <= 4'd1;
            else if (state == EXPAND && cnt != NR_L)
                cnt <= cnt + 4'd1;
        end
    end

    // Round-key file: capture the cipher key, then one expanded key per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (handshake) begin
                rk[0] <= key_in;
                work  <= key_in;
            end else if (state == EXPAND) begin
                rk[cnt] <= next_rk;
                work    <= next_rk;
            end
        end
    end

    // Registered read port in decryption order; out-of-range rounds read zero.
    always_ff @(posedge clk) begin
        if (rst)
            rd_key <= 128'h0;
        else if (rd_round > NR_L)
            rd_key <= 128'h0;
        else
            rd_key <= rk[NR_L - rd_round];
    end

endmodule

// File: tb/tb_aes128_dec_key_store.sv
// Self-checking bench for aes128_dec_key_store.
module tb_aes128_dec_key_store;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;
    logic         keys_valid;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;

    always #5 clk = ~clk;

    aes128_dec_key_store dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .keys_valid (keys_valid),
        .rd_round   (rd_round),
        .rd_key     (rd_key)
    );

    localparam logic [127:0] V2_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    typedef struct {
        int           due;
        logic [3:0]   r;
        logic [127:0] exp;
    } sb_t;

    sb_t          sb_q[$];
    logic [127:0] a1_rk [0:10];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare each read result on the negedge after the edge that registered it.
    always @(negedge clk) begin
        sb_t e;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            if (e.due == cyc)
                chk($sformatf("rd_round%0d", e.r), rd_key, e.exp);
            else
                chk("sb_stale", 128'(e.due), 128'(cyc));
        end
    end

    task automatic rd_issue(input logic [3:0] r, input logic [127:0] exp);
        sb_t e;
        rd_round = r;
        e.due = cyc + 1;
        e.r   = r;
        e.exp = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic sb_drain();
        @(posedge clk);
        #1;
        chk("sb_drain", 128'(sb_q.size()), 128'd0);
    endtask

    // Handshake a key and track the 10-cycle expansion; optionally pulse a
    // competing key while busy.
    task automatic load_key(input logic [127:0] k, input int busy_k);
        key_in    = k;
        key_valid = 1'b1;
        chk("ready_pre", 128'(key_ready), 128'd1);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        for (int k2 = 0; k2 <= 10; k2++) begin
            if (k2 == busy_k) begin
                key_in    = ~k;
                key_valid = 1'b1;
            end else if (k2 == busy_k + 1) begin
                key_valid = 1'b0;
            end
            @(negedge clk);
            if (k2 == 0) begin
                chk("kv_drop", 128'(keys_valid), 128'd0);
                chk("busy_ready", 128'(key_ready), 128'd0);
            end
            if (k2 == busy_k) chk("busy_ignored_ready", 128'(key_ready), 128'd0);
            if (k2 == 9)  chk("kv_pre", 128'(keys_valid), 128'd0);
            if (k2 == 10) begin
                chk("kv_rise", 128'(keys_valid), 128'd1);
                chk("ready_post", 128'(key_ready), 128'd1);
            end
            @(posedge clk);
            #1;
        end
        key_valid = 1'b0;
    endtask

    initial begin
        a1_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        a1_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        a1_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        a1_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        a1_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        a1_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        a1_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        a1_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        a1_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        a1_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        a1_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset with a key offered: reset wins, nothing captured.
        rst       = 1'b1;
        key_valid = 1'b1;
        key_in    = a1_rk[0];
        rd_round  = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 128'(key_ready), 128'd1);
        chk("rst_kv", 128'(keys_valid), 128'd0);
        chk("rst_rdkey", rd_key, 128'h0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        key_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ready", 128'(key_ready), 128'd1);
        chk("idle_kv", 128'(keys_valid), 128'd0);

        // FIPS-197 A.1 with a competing key pulsed mid-expansion.
        load_key(a1_rk[0], 4);
        for (int r = 0; r <= 10; r++) rd_issue(4'(r), a1_rk[10 - r]);
        rd_issue(4'd11, 128'h0);
        rd_issue(4'd15, 128'h0);
        rd_issue(4'd0, a1_rk[10]);
        sb_drain();

        // Rekey from READY with the second vector.
        load_key(V2_KEY, -1);
        rd_issue(4'd0, V2_RK10);
        rd_issue(4'd10, V2_KEY);
        rd_issue(4'd12, 128'h0);
        sb_drain();

        // Reset during expansion abandons it.
        key_in    = a1_rk[0];
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_kv", 128'(keys_valid), 128'd0);
        chk("mid_rst_ready", 128'(key_ready), 128'd1);
        chk("mid_rst_rdkey", rd_key, 128'h0);
        repeat (12) @(posedge clk);
        #1;
        chk("mid_rst_hold_kv", 128'(keys_valid), 128'd0);
        chk("mid_rst_hold_ready", 128'(key_ready), 128'd1);

        // Fresh load after the abandoned expansion.
        load_key(a1_rk[0], -1);
        rd_issue(4'd0, a1_rk[10]);
        rd_issue(4'd9, a1_rk[1]);
        rd_issue(4'd5, a1_rk[5]);
        rd_issue(4'd10, a1_rk[0]);
        sb_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
